// File: rtl/xbar_pkg.sv
// Shared constants and helpers for the 2x2 crossbar arbiter and its datapath.
package xbar_pkg;

  localparam logic XBAR_STRAIGHT = 1'b0;
  localparam logic XBAR_CROSS    = 1'b1;
  localparam logic DEST_OUT1     = 1'b0;
  localparam logic DEST_OUT2     = 1'b1;
  localparam int   DW_DEFAULT    = 4;

  // Setting that steers requester in1 (from_in2=0) or in2 (from_in2=1) to dest.
  function automatic logic route_ctrl(input logic from_in2, input logic dest);
    return (dest ^ from_in2) ? XBAR_CROSS : XBAR_STRAIGHT;
  endfunction

endpackage

// File: rtl/crossbar_2x2_arbiter_datapath.sv
// Existing 2x2 crossbar datapath: straight (in1->out1, in2->out2) or cross.
module Crossbar_2x2_4bit
  import xbar_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          control,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  output logic [DW-1:0] out1,
  output logic [DW-1:0] out2
);

  assign out1 = (control == XBAR_CROSS) ? in2 : in1;
  assign out2 = (control == XBAR_CROSS) ? in1 : in2;

endmodule

// File: rtl/crossbar_2x2_arbiter.sv
// Round-robin arbiter driving the 2x2 crossbar with per-output holding registers.
// Optional saturating conflict counter enabled by defining XBAR_CONFLICT_CNT_EN.
module crossbar_2x2_arbiter
  import xbar_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in1_valid,
  input  logic          in1_dest,
  input  logic [DW-1:0] in1_data,
  output logic          in1_ready,
  input  logic          in2_valid,
  input  logic          in2_dest,
  input  logic [DW-1:0] in2_data,
  output logic          in2_ready,
  output logic          out1_valid,
  output logic [DW-1:0] out1_data,
  input  logic          out1_ready,
  output logic          out2_valid,
  output logic [DW-1:0] out2_data,
  input  logic          out2_ready,
  output logic          control
`ifdef XBAR_CONFLICT_CNT_EN
  ,
  output logic [7:0]    conflict_cnt
`endif
);

  logic                 control_reg;
  logic                 ctrl_next;
  logic                 prio_reg;
  logic                 conflict;
  logic                 grant1;
  logic                 grant2;
  logic                 accept1;
  logic                 accept2;
  logic [1:0]           out_valid_reg;
  logic [1:0][DW-1:0]   out_data_reg;
  logic [1:0][DW-1:0]   xbar_out;
  logic [1:0]           out_ready;
  logic [1:0]           space;
  logic [1:0]           load;

  assign out_ready = {out2_ready, out1_ready};
  assign conflict  = in1_valid && in2_valid && (in1_dest == in2_dest);

  // Idle cycles keep the previous setting so the datapath does not glitch.
  always_comb begin
    grant1    = 1'b0;
    grant2    = 1'b0;
    ctrl_next = control_reg;
    if (conflict) begin
      if (!prio_reg) begin
        grant1    = 1'b1;
        ctrl_next = route_ctrl(1'b0, in1_dest);
      end else begin
        grant2    = 1'b1;
        ctrl_next = route_ctrl(1'b1, in2_dest);
      end
    end else begin
      grant1 = in1_valid;
      grant2 = in2_valid;
      if (in1_valid) begin
        ctrl_next = route_ctrl(1'b0, in1_dest);
      end else if (in2_valid) begin
        ctrl_next = route_ctrl(1'b1, in2_dest);
      end
    end
  end

  // A granted word waits for its own destination; it is never rerouted.
  assign accept1   = rst_n && grant1 && space[in1_dest];
  assign accept2   = rst_n && grant2 && space[in2_dest];
  assign in1_ready = accept1;
  assign in2_ready = accept2;
  assign control   = ctrl_next;

  Crossbar_2x2_4bit #(
    .DW(DW)
  ) u_xbar (
    .control(ctrl_next),
    .in1    (in1_data),
    .in2    (in2_data),
    .out1   (xbar_out[0]),
    .out2   (xbar_out[1])
  );

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_out
      assign space[gi] = !out_valid_reg[gi] || out_ready[gi];
      assign load[gi]  = (accept1 && (in1_dest == 1'(gi))) ||
                         (accept2 && (in2_dest == 1'(gi)));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid_reg[gi] <= 1'b0;
          out_data_reg[gi]  <= '0;
        end else if (load[gi]) begin
          out_valid_reg[gi] <= 1'b1;
          out_data_reg[gi]  <= xbar_out[gi];
        end else if (out_ready[gi]) begin
          out_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign out1_valid = out_valid_reg[0];
  assign out2_valid = out_valid_reg[1];
  assign out1_data  = out_data_reg[0];
  assign out2_data  = out_data_reg[1];

  // Pointer only advances once the conflict winner actually moves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      control_reg <= XBAR_STRAIGHT;
      prio_reg    <= 1'b0;
    end else begin
      control_reg <= ctrl_next;
      if (conflict && (accept1 || accept2)) begin
        prio_reg <= !prio_reg;
      end
    end
  end

`ifdef XBAR_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_cnt_reg <= 8'd0;
    end else if (conflict && (conflict_cnt_reg != 8'hFF)) begin
      conflict_cnt_reg <= conflict_cnt_reg + 8'd1;
    end
  end

  assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_crossbar_2x2_arbiter.sv
// Directed scoreboard bench for crossbar_2x2_arbiter; expected words queued per output.
module tb_crossbar_2x2_arbiter;

  logic       clk;
  logic       rst_n;
  logic       in1_valid, in1_dest, in1_ready;
  logic       in2_valid, in2_dest, in2_ready;
  logic [3:0] in1_data, in2_data;
  logic       out1_valid, out1_ready, out2_valid, out2_ready;
  logic [3:0] out1_data, out2_data;
  logic       control;
`ifdef XBAR_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
`endif

  int         n_vec  = 0;
  int         n_fail = 0;
  int         cnt_exp = 0;
  logic [3:0] q1[$];
  logic [3:0] q2[$];

  crossbar_2x2_arbiter #(.DW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1_valid (in1_valid),
    .in1_dest  (in1_dest),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .in2_valid (in2_valid),
    .in2_dest  (in2_dest),
    .in2_data  (in2_data),
    .in2_ready (in2_ready),
    .out1_valid(out1_valid),
    .out1_data (out1_data),
    .out1_ready(out1_ready),
    .out2_valid(out2_valid),
    .out2_data (out2_data),
    .out2_ready(out2_ready),
    .control   (control)
`ifdef XBAR_CONFLICT_CNT_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "/out1_valid"}, 32'(out1_valid), 32'(q1.size() != 0));
    if (q1.size() != 0) chk({tag, "/out1_data"}, 32'(out1_data), 32'(q1[0]));
    chk({tag, "/out2_valid"}, 32'(out2_valid), 32'(q2.size() != 0));
    if (q2.size() != 0) chk({tag, "/out2_data"}, 32'(out2_data), 32'(q2[0]));
`ifdef XBAR_CONFLICT_CNT_EN
    chk({tag, "/conflict_cnt"}, 32'(conflict_cnt), 32'(cnt_exp));
`endif
  endtask

  // One cycle: drive, check same-cycle handshake/control, update model, check outputs.
  task automatic step(input string tag,
                      input logic v1, input logic d1, input logic [3:0] x1,
                      input logic v2, input logic d2, input logic [3:0] x2,
                      input logic er1, input logic er2, input logic ec);
    in1_valid = v1; in1_dest = d1; in1_data = x1;
    in2_valid = v2; in2_dest = d2; in2_data = x2;
    #1;
    chk({tag, "/in1_ready"}, 32'(in1_ready), 32'(er1));
    chk({tag, "/in2_ready"}, 32'(in2_ready), 32'(er2));
    chk({tag, "/control"},   32'(control),   32'(ec));
    if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
    if (q2.size() != 0 && out2_ready) void'(q2.pop_front());
    if (er1) begin
      if (d1) q2.push_back(x1); else q1.push_back(x1);
    end
    if (er2) begin
      if (d2) q2.push_back(x2); else q1.push_back(x2);
    end
    if (v1 && v2 && (d1 == d2)) cnt_exp = (cnt_exp == 255) ? 255 : cnt_exp + 1;
    @(posedge clk);
    #1;
    chk_outputs(tag);
    $display("step %s: in1_ready=%0b in2_ready=%0b control=%0b out1=%0b/%h out2=%0b/%h",
             tag, er1, er2, ec, out1_valid, out1_data, out2_valid, out2_data);
  endtask

  initial begin
    rst_n = 1'b0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in1_valid = 1'($urandom); in1_dest = 1'($urandom); in1_data = 4'($urandom);
      in2_valid = 1'($urandom); in2_dest = 1'($urandom); in2_data = 4'($urandom);
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1;
    in1_valid = 1'b0; in2_valid = 1'b0;
    #1;
    chk("reset/control", 32'(control), 32'd0);
    chk("reset/out1_data", 32'(out1_data), 32'd0);
    chk("reset/out2_data", 32'(out2_data), 32'd0);
    chk_outputs("reset");

    // Straight, cross, simultaneous drain+load.
    step("straight",  1, 0, 4'hA, 1, 1, 4'h5, 1, 1, 0);
    step("cross",     1, 1, 4'h3, 1, 0, 4'hC, 1, 1, 1);
    // Conflict on out1: in1 wins, in2 follows one cycle later.
    step("conf0_a",   1, 0, 4'h1, 1, 0, 4'h2, 1, 0, 0);
    step("conf0_b",   0, 0, 4'h1, 1, 0, 4'h2, 0, 1, 1);
    step("idle_hold", 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 1);
    // Repeat conflict: pointer now favours in2.
    step("conf1_a",   1, 0, 4'h1, 1, 0, 4'h2, 0, 1, 1);
    step("conf1_b",   1, 0, 4'h1, 0, 0, 4'h2, 1, 0, 0);
    // Backpressure on out1.
    out1_ready = 1'b0;
    step("bp_a",      1, 0, 4'h7, 0, 0, 4'h0, 0, 0, 0);
    step("bp_b",      1, 0, 4'h7, 0, 0, 4'h0, 0, 0, 0);
    out1_ready = 1'b1;
    step("bp_rel",    1, 0, 4'h7, 0, 0, 4'h0, 1, 0, 0);
    // Stalled conflict keeps the pointer; loser not rerouted to idle out2.
    out1_ready = 1'b0;
    step("stall_conf", 1, 0, 4'h1, 1, 0, 4'h2, 0, 0, 0);
    out1_ready = 1'b1;
    step("unstall_a", 1, 0, 4'h1, 1, 0, 4'h2, 1, 0, 0);
    step("unstall_b", 0, 0, 4'h1, 1, 0, 4'h2, 0, 1, 1);
    // Conflict on out2 with pointer on in2.
    step("conf2_a",   1, 1, 4'h8, 1, 1, 4'h9, 0, 1, 0);
    step("conf2_b",   1, 1, 4'h8, 0, 1, 4'h9, 1, 0, 1);
    // Load out1 while out2 is blocked, then reset mid-transfer.
    out1_ready = 1'b0; out2_ready = 1'b0;
    step("blk2",      1, 0, 4'hE, 1, 1, 4'hF, 1, 0, 0);
    rst_n = 1'b0;
    in1_valid = 1'b0; in2_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q1.delete(); q2.delete(); cnt_exp = 0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    #1;
    chk("rst_mid/control", 32'(control), 32'd0);
    chk("rst_mid/out1_data", 32'(out1_data), 32'd0);
    chk_outputs("rst_mid");
    // Pointer back to in1 after reset; three conflicts alternate winners.
    step("cnt_a",     1, 1, 4'h4, 1, 1, 4'h6, 1, 0, 1);
    step("cnt_b",     1, 1, 4'h4, 1, 1, 4'h6, 0, 1, 0);
    step("cnt_c",     1, 1, 4'h4, 1, 1, 4'h6, 1, 0, 1);

`ifdef XBAR_CONFLICT_CNT_EN
    chk("cnt3", 32'(conflict_cnt), 32'd3);
    in1_valid = 1'b1; in1_dest = 1'b0; in1_data = 4'h1;
    in2_valid = 1'b1; in2_dest = 1'b0; in2_data = 4'h2;
    repeat (300) @(posedge clk);
    #1;
    chk("cnt_sat", 32'(conflict_cnt), 32'd255);
    $display("step cnt_sat: conflict_cnt=%0d", conflict_cnt);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/crossbar_2x2_arbiter.md
# crossbar_2x2_arbiter

- Arbitrates two 4-bit requester streams onto the 2x2 crossbar's two output ports.
- Each cycle it picks the crossbar `control` setting from the destination requests, resolves same-destination conflicts round-robin, and registers the routed data into per-output holding registers with valid/ready handshakes.
- Sits between the requesters and downstream consumers.
- Owns the only `control` driver of the crossbar datapath.

## Interface
- `DW`, default 4: data width per port.
- `clk` input, 1: sole clock; all state updates on rising edge.
- `rst_n` input, 1: synchronous, active-low reset.
- `in1_valid`, `in2_valid` input, 1: requester has a word.
- `in1_dest`, `in2_dest` input, 1: destination; 0 = out1, 1 = out2.
- `in1_data`, `in2_data` input, DW: request payload.
- `in1_ready`, `in2_ready` output, 1: word accepted this cycle (valid && ready).
- `out1_valid`, `out2_valid` output, 1: holding register occupied.
- `out1_data`, `out2_data` output, DW: holding register contents.
- `out1_ready`, `out2_ready` input, 1: consumer takes the word this cycle.
- `control` output, 1: crossbar setting for the current cycle; 0 = straight, 1 = cross.
- `conflict_cnt` output, 8: only with `XBAR_CONFLICT_CNT_EN`.

## Operation
- **Routing:** straight maps in1→out1 and in2→out2; cross maps in1→out2 and in2→out1.
- **Output space:** output k has space when `!outk_valid || outk_ready`.
- **Request resolution, per cycle:**
  - Both valid, different destinations: `control = in1_dest`; both granted.
  - Both valid, same destination d (conflict): winner = in1 if `prio == 0`, else in2. `control` routes the winner to d. The loser's `ready` = 0.
  - One valid: `control` routes it to its destination.
  - None valid: `control` holds its last registered value.
- **Acceptance:** a granted input is accepted iff its destination has space.
  - On acceptance, the routed data loads that output register and sets `outk_valid`.
  - `outk_valid` clears when `outk_ready` is high with no new load.
- **Round-robin pointer `prio`:** toggles only when a conflict winner is actually accepted. A stalled conflict keeps `prio`.
- **Conflict with blocked destination:** the loser is still not accepted, even though the other output is idle. This is strict destination ordering, with no rerouting.
- **Handshake rules:**
  - `inX_ready` may depend combinationally on `valid`/`dest`/`out*_ready`.
  - Requesters hold `data`/`dest` while `valid && !ready`.
  - Outputs hold `data` stable while `valid && !ready`.

## Timing
- **Reset** (`rst_n` low at an edge): `out1_valid = out2_valid = 0`, `out1_data = out2_data = 0`, `control = 0`, `prio = 0`, `conflict_cnt = 0`. Reset mid-transfer discards held words.
- **Latency:** accepted word appears on its `outk_data`/`outk_valid` one cycle after acceptance.
- **Throughput:**
  - 2 words/cycle with no conflict and no backpressure.
  - A conflict costs the loser exactly one extra cycle when unblocked.
- **Simultaneous load and drain:** on the same output, the new word replaces the drained one; valid stays 1.
- **`control` register:** registered copy of the last applied setting. The combinational path into the datapath uses the current-cycle decision.

## Configuration
- **`XBAR_CONFLICT_CNT_EN` defined:** `conflict_cnt` port exists.
  - Increments by 1 on each cycle with a conflict (both valid, same dest), whether or not the winner is accepted.
  - Saturates at 255.
  - Resets to 0.
- **Undefined:** port and counter logic are absent; all other behaviour is identical.

## Structure
- Shared package `xbar_pkg` holds:
  - `XBAR_STRAIGHT = 1'b0`, `XBAR_CROSS = 1'b1`.
  - `DEST_OUT1 = 1'b0`, `DEST_OUT2 = 1'b1`.
  - Default `DW = 4`.
- One sub-module: the team's existing `Crossbar_2x2_4bit` datapath, instantiated once with `control` from the arbiter. Its outputs feed the holding registers.
- Arbitration, pointer, holding registers and optional counter are all in this module.

## Test plan
- **Reset:** hold `rst_n = 0` for 2 cycles with inputs random → `out*_valid = 0`, `control = 0`, `conflict_cnt = 0` after release.
- **Straight:** `in1 = 4'hA` dest 0, `in2 = 4'h5` dest 1, outputs ready → both ready = 1, `control = 0`; next cycle `out1 = A`, `out2 = 5`, both valid.
- **Cross:** `in1 = 4'h3` dest 1, `in2 = 4'hC` dest 0 → `control = 1`; next cycle `out1 = C`, `out2 = 3`.
- **Conflict round-robin:** `in1 = 1`, `in2 = 2`, both dest 0, held.
  - Cycle 0: `in1_ready = 1`, `in2_ready = 0`.
  - Cycle 1: `out1 = 1`, `in2` accepted.
  - Cycle 2: `out1 = 2`.
  - Repeat the conflict: in2 wins first.
- **Backpressure:** out1 full with `out1_ready = 0`, `in1 = 7` dest 0 → `in1_ready = 0`, `out1_data` unchanged. Raise `out1_ready` → same cycle `in1_ready = 1`, next cycle `out1 = 7`.
- **Counter (macro on):** 3 conflict cycles → `conflict_cnt = 3`. 300 conflict cycles → 255.
